// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch stage: the buffer entry
// layout, the FSM state encoding and B-type immediate extraction.
package fetch_pkg;

   localparam int         FETCH_XLEN = 64;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam int         INST_BYTES = 4;

   typedef struct packed {
      logic [FETCH_XLEN-1:0] pc;
      logic [31:0]           inst;
      logic                  fault;
      logic                  pred_taken;
   } fetch_entry_t;

   typedef enum logic {
      ST_RUN,
      ST_HALT
   } fetch_state_t;

   // B-type immediate imm[12|10:5|4:1|11], sign-extended to the PC width.
   function automatic logic [FETCH_XLEN-1:0] b_imm(input logic [31:0] inst);
      return {{(FETCH_XLEN-13){inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small circular buffer between fetch and decode. Flush has priority over
// enqueue and dequeue; DEPTH must be a power of two so pointers wrap naturally.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int  DEPTH   = 2,
   parameter type entry_t = fetch_entry_t,
   localparam int PTR_W   = $clog2(DEPTH),
   localparam int CNT_W   = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enq,
   input  entry_t           enq_data,
   input  logic             deq,
   input  logic             flush,
   output logic [CNT_W-1:0] count,
   output entry_t           head
);

   entry_t           mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
         if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count + CNT_W'(enq) - CNT_W'(deq);
      end
   end

   // NOTE: storage is deliberately not reset; count alone decides validity,
   // so the payload flops stay plain registers without a reset tree.
   always_ff @(posedge clk) begin
      if (enq && !flush) mem[wr_ptr] <= enq_data;
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC register, fault check, fetch buffer and redirect handling.
// Optional macro STATIC_PREDICT_EN enables backward-taken branch prediction.
module instruction_fetch
   import fetch_pkg::*;
#(
   parameter int              XLEN       = 64,
   parameter logic [XLEN-1:0] RESET_PC   = '0,
   parameter int              BUF_DEPTH  = 2,
   parameter int              IMEM_BYTES = 512
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic [XLEN-1:0] imem_addr,
   input  logic [31:0]     imem_inst,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [31:0]     out_inst,
   output logic            out_fault,
   output logic            out_pred_taken
);

   localparam int CNT_W = $clog2(BUF_DEPTH + 1);

   fetch_state_t     state_q;
   fetch_state_t     state_d;
   logic [XLEN-1:0]  pc_q;
   logic [XLEN-1:0]  pc_next;
   logic [CNT_W-1:0] count;
   fetch_entry_t     head;
   fetch_entry_t     new_entry;
   fetch_entry_t     shown;
   logic             fault;
   logic             pred;
   logic             enq;
   logic             deq;

   assign imem_addr = pc_q;
   assign fault     = (pc_q[1:0] != 2'b00) || (pc_q > XLEN'(IMEM_BYTES - INST_BYTES));

`ifdef STATIC_PREDICT_EN
   assign pred    = !fault && (imem_inst[6:0] == OPC_BRANCH) && imem_inst[31];
   assign pc_next = pred ? pc_q + b_imm(imem_inst) : pc_q + XLEN'(INST_BYTES);
`else
   assign pred    = 1'b0;
   assign pc_next = pc_q + XLEN'(INST_BYTES);
`endif

   assign out_valid = (count != '0);
   assign deq       = out_valid && out_ready;
   // A full buffer still accepts a new entry when its head leaves this cycle.
   assign enq       = (state_q == ST_RUN) && !redirect_valid
                      && ((count < CNT_W'(BUF_DEPTH)) || deq);

   assign new_entry = '{pc: pc_q, inst: fault ? 32'h0 : imem_inst, fault: fault, pred_taken: pred};

   fetch_fifo #(
      .DEPTH   (BUF_DEPTH),
      .entry_t (fetch_entry_t)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .enq      (enq),
      .enq_data (new_entry),
      .deq      (deq),
      .flush    (redirect_valid),
      .count    (count),
      .head     (head)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q    <= RESET_PC;
         state_q <= ST_RUN;
      end else begin
         state_q <= state_d;
         if (redirect_valid) pc_q <= redirect_pc;
         else if (enq)       pc_q <= pc_next;
      end
   end

   always_comb begin
      // NOTE: default first so every path assigns state_d and no latch forms.
      state_d = state_q;
      if (redirect_valid)     state_d = ST_RUN;
      else if (enq && fault)  state_d = ST_HALT;
   end

   assign shown          = out_valid ? head : '0;
   assign out_pc         = shown.pc;
   assign out_inst       = shown.inst;
   assign out_fault      = shown.fault;
   assign out_pred_taken = shown.pred_taken;

endmodule
